csr_trap_unit: RTL

// - Parametrised machine-mode CSR file with trap/interrupt engine. Sits in the decode/execute stage

---
 rtl/csr_trap_unit_if.sv | 12 +
 rtl/csr_trap_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit_if.sv
// CSR access bus between the controller (master) and the CSR/trap unit (slave).
// Read data and the illegal flag are combinational on the current address and op.
interface csr_trap_unit_if;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        illegal;

    modport master (output op, addr, wdata, input rdata, illegal);
    modport slave  (input op, addr, wdata, output rdata, illegal);
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry/return, level interrupt arbitration and a 64-bit cycle counter.
// Optional feature macro: CSR_INSTRET_EN adds the 64-bit minstret counter at B02/B82.
module csr_trap_unit #(
    parameter logic [31:0] TVEC_ADDRESS = 32'h0,
    parameter int          NUM_IRQ      = 4,
    parameter int          NUM_SCRATCH  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    csr_trap_unit_if.slave     csr_if,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               trap_i,
    input  logic [4:0]         trap_cause_i,
    input  logic               trap_irq_i,
    input  logic               mret_i,
    input  logic               instret_i,
    input  logic [31:0]        pc_i,
    output logic [31:0]        epc_o,
    output logic [31:0]        tvec_o,
    output logic               irq_req_o,
    output logic [4:0]         irq_id_o
);
    localparam int          NS       = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;
    localparam logic [31:0] MIE_MASK = ((32'h1 << NUM_IRQ) - 32'h1) << 16;
    localparam logic [1:0]  OP_NONE  = 2'b00;
    localparam logic [1:0]  OP_WRITE = 2'b01;
    localparam logic [1:0]  OP_SET   = 2'b10;
    localparam logic [1:0]  OP_CLEAR = 2'b11;

    logic               sts_mie_q, sts_mie_d;
    logic               sts_mpie_q, sts_mpie_d;
    logic [31:0]        mie_q, mie_d;
    logic [31:0]        mtvec_q, mtvec_d;
    logic [31:0]        mscratch_q, mscratch_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [63:0]        mcycle_q, mcycle_d;
    logic [31:0]        scratch_q [NS];
    logic [31:0]        scratch_d [NS];
    logic [NUM_IRQ-1:0] mip_q, mip_d;
    logic               irq_req_q, irq_req_d;
    logic [4:0]         irq_id_q, irq_id_d;
`ifdef CSR_INSTRET_EN
    logic [63:0]        minstret_q, minstret_d;
`else
    logic               unused_instret;
    assign unused_instret = instret_i;
`endif

    logic [31:0] mip_word, pending, old_val, wval;
    logic        mapped, read_only, csr_we;

    assign mip_word = 32'(mip_q) << 16;
    assign pending  = mip_word & mie_q;

    always_comb begin
        old_val   = '0;
        mapped    = 1'b1;
        read_only = 1'b0;
        case (csr_if.addr)
            12'h300: old_val = {19'b0, 2'b11, 3'b0, sts_mpie_q, 3'b0, sts_mie_q, 3'b0};
            12'h304: old_val = mie_q;
            12'h305: old_val = mtvec_q;
            12'h340: old_val = mscratch_q;
            12'h341: old_val = mepc_q;
            12'h342: old_val = mcause_q;
            12'h344: begin
                old_val   = mip_word;
                read_only = 1'b1;
            end
            12'hB00: old_val = mcycle_q[31:0];
            12'hB80: old_val = mcycle_q[63:32];
`ifdef CSR_INSTRET_EN
            12'hB02: old_val = minstret_q[31:0];
            12'hB82: old_val = minstret_q[63:32];
`endif
            default: mapped = 1'b0;
        endcase
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (csr_if.addr == 12'h7C0 + 12'(i)) begin
                mapped  = 1'b1;
                old_val = scratch_q[i];
            end
        end
    end

    assign csr_if.illegal = (csr_if.op != OP_NONE) && (!mapped || read_only);
    assign csr_if.rdata   = csr_if.illegal ? 32'h0 : old_val;
    // A trap or mret flushes the CSR instruction sharing its cycle.
    assign csr_we = (csr_if.op != OP_NONE) && !csr_if.illegal && !trap_i && !mret_i;

    always_comb begin
        case (csr_if.op)
            OP_WRITE: wval = csr_if.wdata;
            OP_SET:   wval = old_val | csr_if.wdata;
            OP_CLEAR: wval = old_val & ~csr_if.wdata;
            default:  wval = old_val;
        endcase
    end

    always_comb begin
        sts_mie_d  = sts_mie_q;
        sts_mpie_d = sts_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        scratch_d  = scratch_q;
        mcycle_d   = mcycle_q + 64'd1;
`ifdef CSR_INSTRET_EN
        minstret_d = minstret_q + 64'(instret_i);
`endif
        if (csr_we) begin
            case (csr_if.addr)
                12'h300: begin
                    sts_mie_d  = wval[3];
                    sts_mpie_d = wval[7];
                end
                12'h304: mie_d      = wval & MIE_MASK;
                12'h305: mtvec_d    = wval & ~32'h2;
                12'h340: mscratch_d = wval;
                12'h341: mepc_d     = {wval[31:2], 2'b00};
                12'h342: mcause_d   = wval;
                12'hB00: mcycle_d   = {mcycle_q[63:32], wval};
                12'hB80: mcycle_d   = {wval, mcycle_q[31:0]};
`ifdef CSR_INSTRET_EN
                12'hB02: minstret_d = {minstret_q[63:32], wval};
                12'hB82: minstret_d = {wval, minstret_q[31:0]};
`endif
                default: ;
            endcase
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (csr_if.addr == 12'h7C0 + 12'(i)) scratch_d[i] = wval;
            end
        end
        if (trap_i) begin
            mepc_d     = {pc_i[31:2], 2'b00};
            mcause_d   = {trap_irq_i, 26'b0, trap_cause_i};
            sts_mpie_d = sts_mie_q;
            sts_mie_d  = 1'b0;
        end else if (mret_i) begin
            sts_mie_d  = sts_mpie_q;
            sts_mpie_d = 1'b1;
        end
        mip_d     = irq_i;
        irq_req_d = sts_mie_q && (|pending);
        irq_id_d  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[16+i]) irq_id_d = 5'(16 + i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sts_mie_q  <= 1'b0;
            sts_mpie_q <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= TVEC_ADDRESS & ~32'h2;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            for (int i = 0; i < NS; i++) scratch_q[i] <= '0;
            mip_q      <= '0;
            irq_req_q  <= 1'b0;
            irq_id_q   <= '0;
`ifdef CSR_INSTRET_EN
            minstret_q <= '0;
`endif
        end else begin
            sts_mie_q  <= sts_mie_d;
            sts_mpie_q <= sts_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            scratch_q  <= scratch_d;
            mip_q      <= mip_d;
            irq_req_q  <= irq_req_d;
            irq_id_q   <= irq_id_d;
`ifdef CSR_INSTRET_EN
            minstret_q <= minstret_d;
`endif
        end
    end

    assign epc_o     = mepc_q;
    assign tvec_o    = (mtvec_q[0] && mcause_q[31])
                       ? {mtvec_q[31:2], 2'b00} + {25'b0, mcause_q[4:0], 2'b00}
                       : {mtvec_q[31:2], 2'b00};
    assign irq_req_o = irq_req_q;
    assign irq_id_o  = irq_id_q;
endmodule
